// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the result entry type passed downstream of the atan pipeline.
package cordic_pkg;

  localparam int unsigned CORDIC_WIDTH     = 16;
  localparam int unsigned CORDIC_ORDER     = 12;
  localparam int unsigned CORDIC_MODE_ATAN = 2;
  localparam int unsigned CORDIC_LAT       = CORDIC_ORDER + 1;
  localparam int unsigned CORDIC_TAG_W     = 8;
  localparam int unsigned CORDIC_DEPTH     = 8;

  typedef struct packed {
    logic [CORDIC_WIDTH-1:0] atan;
    logic [CORDIC_TAG_W-1:0] tag;
  } atan_entry_t;

endpackage

// File: rtl/cordic_atan_collector_if.sv
// Issue-credit and result-stream signals between the atan collector and its neighbours.
interface cordic_atan_collector_if
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = CORDIC_WIDTH,
  parameter int unsigned TAG_W = CORDIC_TAG_W
) ();

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_allow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_atan;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output issue_valid, issue_tag, out_ready,
    input  issue_allow, out_valid, out_atan, out_tag
  );

  modport slave (
    input  issue_valid, issue_tag, out_ready,
    output issue_allow, out_valid, out_atan, out_tag
  );

endinterface

// File: rtl/cordic_sync_fifo.sv
// First-word fall-through FIFO with a registered head that holds its last value once drained.
module cordic_sync_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     din,
  input  logic                   ready,
  output logic                   valid,
  output logic [ENTRY_W-1:0]     dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      rd_nxt;
  logic               full;
  logic               pop;
  logic               do_push;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = valid & ready;
  assign do_push = push & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_nxt;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head register: next entry on pop, a fresh push into an emptying/empty FIFO, else hold.
      if (pop) begin
        if (count != (PW+1)'(1)) dout <= mem[rd_nxt];
        else if (do_push)        dout <= din;
      end else if (!valid && do_push) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/cordic_atan_collector.sv
// Tracks which CORDIC pipeline slots carry real operands, captures their atan words with tags,
// and buffers them into a valid/ready stream guarded by issue credits.
module cordic_atan_collector
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = CORDIC_WIDTH,
  parameter int unsigned ORDER = CORDIC_ORDER,
  parameter int unsigned DEPTH = CORDIC_DEPTH,
  parameter int unsigned TAG_W = CORDIC_TAG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  cordic_atan_collector_if.slave  bus,
  input  logic [2*WIDTH-1:0]      cordic_res,
  output logic                    drop_err,
  output logic                    ovf_err
);

  localparam int unsigned LAT = ORDER + 1;
  localparam int unsigned IW  = $clog2(LAT + 1);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned SW  = CW + IW;

  logic [LAT-1:0]   dl_v;
  logic [TAG_W-1:0] dl_tag [LAT];
  logic [IW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic [SW-1:0]    occupancy;
  logic             tracked;
  logic             capture;
  logic             fifo_ovf;
  logic [WIDTH+TAG_W-1:0] head;
  logic             unused_res_hi;

  assign tracked   = bus.issue_valid & bus.issue_allow;
  assign capture   = dl_v[LAT-1];
  assign occupancy = SW'(fifo_count) + SW'(inflight);
  // Credit depends only on registered occupancy so it never loops back through issue_valid.
  assign bus.issue_allow = (occupancy < SW'(DEPTH));
  assign unused_res_hi   = ^cordic_res[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_v <= '0;
      for (int unsigned i = 0; i < LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_v      <= {dl_v[LAT-2:0], tracked};
      dl_tag[0] <= bus.issue_tag;
      for (int unsigned i = 1; i < LAT; i++) dl_tag[i] <= dl_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({tracked, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      if (bus.issue_valid && !bus.issue_allow) drop_err <= 1'b1;
      if (fifo_ovf)                            ovf_err  <= 1'b1;
    end
  end

  cordic_sync_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (WIDTH + TAG_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .din   ({cordic_res[WIDTH-1:0], dl_tag[LAT-1]}),
    .ready (bus.out_ready),
    .valid (bus.out_valid),
    .dout  (head),
    .count (fifo_count),
    .ovf   (fifo_ovf)
  );

  assign bus.out_atan = head[WIDTH+TAG_W-1:TAG_W];
  assign bus.out_tag  = head[TAG_W-1:0];

endmodule
